// File: rtl/idli_io_port_m.sv
`timescale 1ns/1ps
// Bridges nibble-serial core word slots to a 4-bit valid/ready link.
// TX: word assembly -> FIFO -> serializer. RX: deserializer -> one-word holding buffer.
module idli_io_port_m #(
  parameter int unsigned TX_DEPTH = 2
) (
  input  logic       i_iop_gck,
  input  logic       i_iop_rst_n,
  input  logic [1:0] i_iop_nib,
  input  logic       i_iop_wr_en,
  input  logic [3:0] i_iop_wr_data,
  input  logic       i_iop_rd_en,
  output logic [3:0] o_iop_rd_data,
  output logic       o_iop_tx_full,
  output logic       o_iop_rx_avail,
  output logic       o_iop_ovf,
  output logic       o_iop_tx_vld,
  output logic [3:0] o_iop_tx_data,
  input  logic       i_iop_tx_rdy,
  input  logic       i_iop_rx_vld,
  input  logic [3:0] i_iop_rx_data,
  output logic       o_iop_rx_rdy
);

  localparam int unsigned AW = $clog2(TX_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {ST_IDLE, ST_SEND} tx_state_e;

  tx_state_e       state_q, state_d;
  logic [15:0]     wr_sr_q, wr_sr_d;
  logic [15:0]     fifo_q [TX_DEPTH];
  logic [15:0]     fifo_d [TX_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     tx_sr_q, tx_sr_d;
  logic [1:0]      tx_cnt_q, tx_cnt_d;
  logic [15:0]     rx_sr_q, rx_sr_d, rx_buf_q, rx_buf_d;
  logic [1:0]      rx_cnt_q, rx_cnt_d;
  logic            rx_avail_q, rx_avail_d;
  logic            slot_q, slot_d;

  logic        push_req, push_ok, pop, fifo_empty, fifo_full;
  logic        rx_take, slot_ok;
  logic [15:0] push_word;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(TX_DEPTH));
  assign push_req   = i_iop_wr_en && (i_iop_nib == 2'd3);
  assign push_word  = {i_iop_wr_data, wr_sr_q[15:4]};

  // Serializer: a pop happens on the IDLE load or on the last-nibble handshake.
  always_comb begin
    state_d  = state_q;
    tx_sr_d  = tx_sr_q;
    tx_cnt_d = tx_cnt_q;
    pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          tx_sr_d  = fifo_q[rd_ptr_q];
          tx_cnt_d = 2'd0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (i_iop_tx_rdy) begin
          if (tx_cnt_q == 2'd3) begin
            tx_cnt_d = 2'd0;
            if (!fifo_empty) begin
              pop     = 1'b1;
              tx_sr_d = fifo_q[rd_ptr_q];
            end else begin
              tx_sr_d = {4'h0, tx_sr_q[15:4]};
              state_d = ST_IDLE;
            end
          end else begin
            tx_sr_d  = {4'h0, tx_sr_q[15:4]};
            tx_cnt_d = tx_cnt_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_sr_d  = wr_sr_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push_ok  = push_req && (!fifo_full || pop);
    ovf_d    = ovf_q | (push_req && !push_ok);
    if (i_iop_wr_en) wr_sr_d = push_word;
    if (push_ok) begin
      fifo_d[wr_ptr_q] = push_word;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // The nib-0 read decision is latched so a mid-slot rx_avail rise cannot join the slot.
  always_comb begin
    rx_sr_d    = rx_sr_q;
    rx_cnt_d   = rx_cnt_q;
    rx_buf_d   = rx_buf_q;
    rx_avail_d = rx_avail_q;
    slot_ok    = (i_iop_nib == 2'd0) ? (i_iop_rd_en && rx_avail_q) : (i_iop_rd_en && slot_q);
    slot_d     = (i_iop_nib == 2'd0) ? slot_ok : slot_q;
    o_iop_rx_rdy = !(rx_avail_q && (rx_cnt_q == 2'd3));
    rx_take    = i_iop_rx_vld && o_iop_rx_rdy;
    if (slot_ok && (i_iop_nib == 2'd3)) rx_avail_d = 1'b0;
    if (rx_take) begin
      rx_sr_d  = {i_iop_rx_data, rx_sr_q[15:4]};
      rx_cnt_d = rx_cnt_q + 2'd1;
      if (rx_cnt_q == 2'd3) begin
        rx_buf_d   = {i_iop_rx_data, rx_sr_q[15:4]};
        rx_avail_d = 1'b1;
      end
    end
    o_iop_rd_data = slot_ok ? rx_buf_q[{i_iop_nib, 2'b00} +: 4] : 4'h0;
  end

  assign o_iop_tx_full  = fifo_full;
  assign o_iop_ovf      = ovf_q;
  assign o_iop_rx_avail = rx_avail_q;
  assign o_iop_tx_vld   = (state_q == ST_SEND);
  assign o_iop_tx_data  = o_iop_tx_vld ? tx_sr_q[3:0] : 4'h0;

  always_ff @(posedge i_iop_gck or negedge i_iop_rst_n) begin
    if (!i_iop_rst_n) begin
      state_q    <= ST_IDLE;
      wr_sr_q    <= '0;
      for (int unsigned i = 0; i < TX_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      tx_sr_q    <= '0;
      tx_cnt_q   <= '0;
      rx_sr_q    <= '0;
      rx_cnt_q   <= '0;
      rx_buf_q   <= '0;
      rx_avail_q <= 1'b0;
      slot_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_sr_q    <= wr_sr_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      tx_sr_q    <= tx_sr_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_sr_q    <= rx_sr_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_buf_q   <= rx_buf_d;
      rx_avail_q <= rx_avail_d;
      slot_q     <= slot_d;
    end
  end

endmodule

// File: tb/tb_idli_io_port_m.sv
`timescale 1ns/1ps
// Directed bench for idli_io_port_m: vector table for the basic TX/RX flows,
// hand-written sequences for FIFO overflow, RX back-pressure, mid-slot avail and reset.
module tb_idli_io_port_m;

  logic       clk, rst_n;
  logic [1:0] nib;
  logic       wr_en, rd_en, tx_rdy, rx_vld;
  logic [3:0] wr_data, rx_data;
  logic [3:0] rd_data, tx_data;
  logic       tx_full, rx_avail, ovf, tx_vld, rx_rdy;

  int n_assert = 0;
  int n_fail   = 0;

  idli_io_port_m #(.TX_DEPTH(2)) dut (
    .i_iop_gck      (clk),
    .i_iop_rst_n    (rst_n),
    .i_iop_nib      (nib),
    .i_iop_wr_en    (wr_en),
    .i_iop_wr_data  (wr_data),
    .i_iop_rd_en    (rd_en),
    .o_iop_rd_data  (rd_data),
    .o_iop_tx_full  (tx_full),
    .o_iop_rx_avail (rx_avail),
    .o_iop_ovf      (ovf),
    .o_iop_tx_vld   (tx_vld),
    .o_iop_tx_data  (tx_data),
    .i_iop_tx_rdy   (tx_rdy),
    .i_iop_rx_vld   (rx_vld),
    .i_iop_rx_data  (rx_data),
    .o_iop_rx_rdy   (rx_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] nib;
    logic       wr_en;
    logic [3:0] wr_data;
    logic       rd_en;
    logic       rx_vld;
    logic [3:0] rx_data;
    logic       e_vld;
    logic [3:0] e_txd;
    logic [3:0] e_rd;
    logic       e_avail;
    logic       e_rxrdy;
    logic       e_full;
    logic       e_ovf;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mkv(logic [1:0] n, logic we, logic [3:0] wd, logic re,
                               logic rv, logic [3:0] rdat, logic ev, logic [3:0] et,
                               logic [3:0] er, logic ea, logic err, logic ef, logic eo);
    vec_t v;
    v.nib = n; v.wr_en = we; v.wr_data = wd; v.rd_en = re;
    v.rx_vld = rv; v.rx_data = rdat; v.e_vld = ev; v.e_txd = et;
    v.e_rd = er; v.e_avail = ea; v.e_rxrdy = err; v.e_full = ef; v.e_ovf = eo;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [3:0] et,
                            input logic [3:0] er, input logic ea, input logic err,
                            input logic ef, input logic eo);
    check({tag, ".tx_vld"},   16'(tx_vld),   16'(ev));
    check({tag, ".tx_data"},  16'(tx_data),  16'(et));
    check({tag, ".rd_data"},  16'(rd_data),  16'(er));
    check({tag, ".rx_avail"}, 16'(rx_avail), 16'(ea));
    check({tag, ".rx_rdy"},   16'(rx_rdy),   16'(err));
    check({tag, ".tx_full"},  16'(tx_full),  16'(ef));
    check({tag, ".ovf"},      16'(ovf),      16'(eo));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input logic [15:0] w);
    for (int i = 0; i < 4; i++) begin
      nib = 2'(i); wr_en = 1'b1; wr_data = w[4*i +: 4];
      step();
    end
    wr_en = 1'b0; nib = 2'd0; wr_data = 4'h0;
  endtask

  task automatic rx_send(input logic [3:0] d);
    rx_vld = 1'b1; rx_data = d;
    #1 check("rx_rdy_before_nibble", 16'(rx_rdy), 16'h1);
    step();
    rx_vld = 1'b0; rx_data = 4'h0;
  endtask

  task automatic read_slot_check(input string tag, input logic [15:0] w);
    logic [15:0] ww;
    ww = w;
    for (int i = 0; i < 4; i++) begin
      nib = 2'(i); rd_en = 1'b1;
      #1 check($sformatf("%s.rd_nib%0d", tag, i), 16'(rd_data), 16'(ww[4*i +: 4]));
      step();
    end
    rd_en = 1'b0; nib = 2'd0;
  endtask

  initial begin
    rst_n = 1'b0; nib = 2'd0; wr_en = 1'b0; wr_data = 4'h0; rd_en = 1'b0;
    tx_rdy = 1'b0; rx_vld = 1'b0; rx_data = 4'h0;

    // Reset state
    #12 check_outs("reset", 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #3 rst_n = 1'b1;
    step();

    // Single word TX (0x1234) then RX word 0xBEAD read back
    vt.push_back(mkv(2'd0, 1, 4'h4, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0, 1, 0, 0));
    vt.push_back(mkv(2'd1, 1, 4'h3, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0, 1, 0, 0));
    vt.push_back(mkv(2'd2, 1, 4'h2, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0, 1, 0, 0));
    vt.push_back(mkv(2'd3, 1, 4'h1, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0, 1, 0, 0));
    vt.push_back(mkv(2'd0, 0, 4'h0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0, 1, 0, 0));
    vt.push_back(mkv(2'd0, 0, 4'h0, 0, 0, 4'h0, 1, 4'h4, 4'h0, 0, 1, 0, 0));
    vt.push_back(mkv(2'd0, 0, 4'h0, 0, 0, 4'h0, 1, 4'h3, 4'h0, 0, 1, 0, 0));
    vt.push_back(mkv(2'd0, 0, 4'h0, 0, 0, 4'h0, 1, 4'h2, 4'h0, 0, 1, 0, 0));
    vt.push_back(mkv(2'd0, 0, 4'h0, 0, 0, 4'h0, 1, 4'h1, 4'h0, 0, 1, 0, 0));
    vt.push_back(mkv(2'd0, 0, 4'h0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0, 1, 0, 0));
    vt.push_back(mkv(2'd0, 0, 4'h0, 0, 1, 4'hD, 0, 4'h0, 4'h0, 0, 1, 0, 0));
    vt.push_back(mkv(2'd0, 0, 4'h0, 0, 1, 4'hA, 0, 4'h0, 4'h0, 0, 1, 0, 0));
    vt.push_back(mkv(2'd0, 0, 4'h0, 0, 1, 4'hE, 0, 4'h0, 4'h0, 0, 1, 0, 0));
    vt.push_back(mkv(2'd0, 0, 4'h0, 0, 1, 4'hB, 0, 4'h0, 4'h0, 0, 1, 0, 0));
    vt.push_back(mkv(2'd0, 0, 4'h0, 1, 0, 4'h0, 0, 4'h0, 4'hD, 1, 1, 0, 0));
    vt.push_back(mkv(2'd1, 0, 4'h0, 1, 0, 4'h0, 0, 4'h0, 4'hA, 1, 1, 0, 0));
    vt.push_back(mkv(2'd2, 0, 4'h0, 1, 0, 4'h0, 0, 4'h0, 4'hE, 1, 1, 0, 0));
    vt.push_back(mkv(2'd3, 0, 4'h0, 1, 0, 4'h0, 0, 4'h0, 4'hB, 1, 1, 0, 0));
    vt.push_back(mkv(2'd0, 0, 4'h0, 1, 0, 4'h0, 0, 4'h0, 4'h0, 0, 1, 0, 0));
    vt.push_back(mkv(2'd0, 0, 4'h0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0, 1, 0, 0));

    tx_rdy = 1'b1;
    for (int i = 0; i < vt.size(); i++) begin
      nib = vt[i].nib; wr_en = vt[i].wr_en; wr_data = vt[i].wr_data; rd_en = vt[i].rd_en;
      rx_vld = vt[i].rx_vld; rx_data = vt[i].rx_data;
      #1 check_outs($sformatf("vec%0d", i), vt[i].e_vld, vt[i].e_txd, vt[i].e_rd,
                    vt[i].e_avail, vt[i].e_rxrdy, vt[i].e_full, vt[i].e_ovf);
      step();
    end
    nib = 2'd0; wr_en = 1'b0; wr_data = 4'h0; rd_en = 1'b0; rx_vld = 1'b0; rx_data = 4'h0;

    // FIFO fill with a stalled link, overflow, then drain back-to-back
    tx_rdy = 1'b0;
    write_slot(16'h1111);
    write_slot(16'h2222);
    write_slot(16'h3333);
    check("fill.tx_full", 16'(tx_full), 16'h1);
    check("fill.ovf", 16'(ovf), 16'h0);
    write_slot(16'h4444);
    check("drop.ovf", 16'(ovf), 16'h1);
    check("drop.tx_full", 16'(tx_full), 16'h1);
    tx_rdy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      check($sformatf("drain%0d.tx_vld", k), 16'(tx_vld), 16'h1);
      check($sformatf("drain%0d.tx_data", k), 16'(tx_data), 16'(k / 4 + 1));
      if (k == 0) check("drain.full_before_pop", 16'(tx_full), 16'h1);
      if (k == 4) check("drain.full_after_pop", 16'(tx_full), 16'h0);
      step();
    end
    check("drain.end_vld", 16'(tx_vld), 16'h0);
    check("drain.ovf_sticky", 16'(ovf), 16'h1);

    // RX back-pressure: three nibbles prefetched while the buffer is full
    rx_send(4'h4); rx_send(4'h3); rx_send(4'h2); rx_send(4'h1);
    check("bp.avail", 16'(rx_avail), 16'h1);
    rx_send(4'h8); rx_send(4'h7); rx_send(4'h6);
    rx_vld = 1'b1; rx_data = 4'h5;
    #1 check("bp.rdy_low0", 16'(rx_rdy), 16'h0);
    step();
    check("bp.rdy_low1", 16'(rx_rdy), 16'h0);
    read_slot_check("bp.first", 16'h1234);
    #1 check("bp.avail_cleared", 16'(rx_avail), 16'h0);
    check("bp.rdy_reopened", 16'(rx_rdy), 16'h1);
    step();
    rx_vld = 1'b0; rx_data = 4'h0;
    #1 check("bp.avail_again", 16'(rx_avail), 16'h1);
    read_slot_check("bp.second", 16'h5678);

    // Word completes mid read slot: slot reads zero and does not pop
    rx_send(4'h1); rx_send(4'h2); rx_send(4'h3);
    nib = 2'd0; rd_en = 1'b1; rx_vld = 1'b1; rx_data = 4'hC;
    #1 check("mid.nib0_rd", 16'(rd_data), 16'h0);
    check("mid.nib0_avail", 16'(rx_avail), 16'h0);
    step();
    rx_vld = 1'b0; rx_data = 4'h0;
    for (int i = 1; i < 4; i++) begin
      nib = 2'(i);
      #1 check($sformatf("mid.nib%0d_rd", i), 16'(rd_data), 16'h0);
      check($sformatf("mid.nib%0d_avail", i), 16'(rx_avail), 16'h1);
      step();
    end
    rd_en = 1'b0; nib = 2'd0;
    #1 check("mid.no_pop", 16'(rx_avail), 16'h1);

    // Reset in the middle of a TX word and an RX word (buffer 0xC321 still held)
    rx_send(4'h9); rx_send(4'h9);
    write_slot(16'h5A5A);
    step();
    step();
    nib = 2'd0; rd_en = 1'b1;
    #1 check("prerst.rd_data", 16'(rd_data), 16'h1);
    check("prerst.tx_data", 16'(tx_data), 16'h5);
    check("prerst.tx_vld", 16'(tx_vld), 16'h1);
    #1 rst_n = 1'b0;
    #1 check_outs("midrst", 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    rd_en = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    step();
    write_slot(16'hCAFE);
    check("post.pop_cycle_vld", 16'(tx_vld), 16'h0);
    step();
    begin
      logic [15:0] w;
      w = 16'hCAFE;
      for (int i = 0; i < 4; i++) begin
        check($sformatf("post.tx_vld%0d", i), 16'(tx_vld), 16'h1);
        check($sformatf("post.tx_data%0d", i), 16'(tx_data), 16'(w[4*i +: 4]));
        step();
      end
    end
    check("post.tx_end", 16'(tx_vld), 16'h0);
    rx_send(4'h9); rx_send(4'h8); rx_send(4'h7); rx_send(4'h6);
    check("post.avail", 16'(rx_avail), 16'h1);
    read_slot_check("post.rd", 16'h6789);
    #1 check("post.avail_cleared", 16'(rx_avail), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
